// File: rtl/cpuDefine.sv
// ----------------------------------------------------------------------------
// cpuDefine -- shared CPU types and constants.
//   DType       : 32-bit datapath word.
//   AluCtrl     : ALU/MDU operation select.
//   MduState    : multiply/divide unit FSM states.
//   MDU_DIV_ITERS : number of radix-2 divide iterations (one quotient bit each).
// Helper functions classify divide operations for the multiply/divide unit.
// ----------------------------------------------------------------------------
package cpuDefine;

   typedef logic [31:0] DType;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_MUL   = 4'd6,
      ALU_MULH  = 4'd7,
      ALU_MULHU = 4'd8,
      ALU_DIV   = 4'd9,
      ALU_MOD   = 4'd10,
      ALU_DIVU  = 4'd11,
      ALU_MODU  = 4'd12
   } AluCtrl;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } MduState;

   localparam int MDU_DIV_ITERS = 32;

   // True for any of the four divide/remainder operations.
   function automatic logic is_div_op(input AluCtrl op);
      return (op == ALU_DIV) || (op == ALU_MOD) || (op == ALU_DIVU) || (op == ALU_MODU);
   endfunction

   // True for the signed divide/remainder operations.
   function automatic logic is_signed_div(input AluCtrl op);
      return (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

endpackage

// File: rtl/div_radix2.sv
// ----------------------------------------------------------------------------
// div_radix2 -- iterative unsigned radix-2 restoring divider datapath.
// Produces one quotient bit per step; the caller holds step high for
// MDU_DIV_ITERS cycles after load and reads quotient/remainder afterwards.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture dividend/divisor, clear remainder and counter
//   step       : perform one iteration
//   dividend   : unsigned dividend (magnitude)
//   divisor    : unsigned divisor (magnitude, nonzero)
//   quotient   : quotient shift register
//   remainder  : partial remainder
//   last       : high during the final iteration step
// ----------------------------------------------------------------------------
module div_radix2
   import cpuDefine::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic step,
   input  DType dividend,
   input  DType divisor,
   output DType quotient,
   output DType remainder,
   output logic last
);

   localparam logic [4:0] LAST_ITER = 5'(MDU_DIV_ITERS - 1);

   logic [4:0]  cnt_r;
   DType        rem_r;
   DType        quot_r;
   DType        dvsr_r;
   logic [32:0] shifted_s;
   logic        ge_s;
   DType        sub_s;

   // Trial subtraction: shift the next dividend bit into the remainder.
   // When shifted >= divisor the true difference fits in 32 bits, so the
   // low-32-bit subtraction is exact.
   always_comb begin
      shifted_s = {rem_r, quot_r[31]};
      ge_s      = (shifted_s >= {1'b0, dvsr_r});
      sub_s     = shifted_s[31:0] - dvsr_r;
   end

   // Remainder, quotient and iteration counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= 5'd0;
         rem_r  <= 32'd0;
         quot_r <= 32'd0;
         dvsr_r <= 32'd0;
      end else if (load) begin
         cnt_r  <= 5'd0;
         rem_r  <= 32'd0;
         quot_r <= dividend;
         dvsr_r <= divisor;
      end else if (step) begin
         cnt_r  <= cnt_r + 5'd1;
         rem_r  <= ge_s ? sub_s : shifted_s[31:0];
         quot_r <= {quot_r[30:0], ge_s};
      end
   end

   assign quotient  = quot_r;
   assign remainder = rem_r;
   assign last      = step && (cnt_r == LAST_ITER);

endmodule

// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit -- multi-cycle multiply / divide unit.
// Multiplies take 2 cycles from accept to done; divides 34 cycles (1 cycle
// for a zero divisor). Signed divides run on magnitudes and FIX applies signs.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request pulse, accepted only when idle and not flushing
//   flush     : abandon any in-flight operation without a done pulse
//   aluctrl   : operation select (latched on accept)
//   aluSrc1   : multiplicand / dividend (latched on accept)
//   aluSrc2   : multiplier / divisor (latched on accept)
//   busy      : high whenever the FSM is not in IDLE
//   done      : one-cycle pulse, result valid in that cycle
//   result    : last completed result, held until overwritten
// ----------------------------------------------------------------------------
module mul_div_unit
   import cpuDefine::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  logic   flush,
   input  AluCtrl aluctrl,
   input  DType   aluSrc1,
   input  DType   aluSrc2,
   output logic   busy,
   output logic   done,
   output DType   result
);

   MduState state_r, fsm_next_s, state_next_s;
   AluCtrl  op_r;
   DType    src1_r, src2_r, result_r, fsm_result_s, result_next_s;
   logic    busy_r, done_r;
   logic    accept_s, in_signed_s;
   DType    dvd_abs_s, dvs_abs_s;
   DType    div_quot_s, div_rem_s;
   logic    div_last_s;
   logic    neg_q_s, neg_r_s;
   logic [32:0]        mul_a_s, mul_b_s;
   logic signed [65:0] prod_s;
   logic [63:0]        prod64_s;
   logic [1:0]         prod_unused_s;

   assign accept_s    = start && (state_r == IDLE) && !flush;
   assign in_signed_s = is_signed_div(aluctrl);
   assign dvd_abs_s   = (in_signed_s && aluSrc1[31]) ? (32'd0 - aluSrc1) : aluSrc1;
   assign dvs_abs_s   = (in_signed_s && aluSrc2[31]) ? (32'd0 - aluSrc2) : aluSrc2;

   div_radix2 u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (accept_s && is_div_op(aluctrl)),
      .step      (state_r == DIV),
      .dividend  (dvd_abs_s),
      .divisor   (dvs_abs_s),
      .quotient  (div_quot_s),
      .remainder (div_rem_s),
      .last      (div_last_s)
   );

   // Only MULH treats its operands as signed; MUL's low word is sign-agnostic.
   assign mul_a_s = {(op_r == ALU_MULH) && src1_r[31], src1_r};
   assign mul_b_s = {(op_r == ALU_MULH) && src2_r[31], src2_r};
   assign prod_s  = $signed({{33{mul_a_s[32]}}, mul_a_s}) * $signed({{33{mul_b_s[32]}}, mul_b_s});
   assign {prod_unused_s, prod64_s} = prod_s;

   assign neg_q_s = is_signed_div(op_r) && (src1_r[31] ^ src2_r[31]);
   assign neg_r_s = is_signed_div(op_r) && src1_r[31];

   // FSM next state and result selection, before flush override.
   always_comb begin
      fsm_next_s   = state_r;
      fsm_result_s = result_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (is_div_op(aluctrl)) begin
                  if (aluSrc2 == 32'd0) begin
                     fsm_next_s   = DONE;
                     fsm_result_s = ((aluctrl == ALU_DIV) || (aluctrl == ALU_DIVU)) ? 32'hFFFF_FFFF : aluSrc1;
                  end else begin
                     fsm_next_s = DIV;
                  end
               end else begin
                  fsm_next_s = MUL;  // illegal ops also pass through MUL, yielding 0
               end
            end else begin
               fsm_next_s = IDLE;
            end
         end
         MUL: begin
            fsm_next_s = DONE;
            case (op_r)
               ALU_MUL:             fsm_result_s = prod64_s[31:0];
               ALU_MULH, ALU_MULHU: fsm_result_s = prod64_s[63:32];
               default:             fsm_result_s = 32'd0;
            endcase
         end
         DIV: begin
            if (div_last_s) begin
               fsm_next_s = FIX;
            end else begin
               fsm_next_s = DIV;
            end
         end
         FIX: begin
            fsm_next_s = DONE;
            case (op_r)
               ALU_DIV:  fsm_result_s = neg_q_s ? (32'd0 - div_quot_s) : div_quot_s;
               ALU_MOD:  fsm_result_s = neg_r_s ? (32'd0 - div_rem_s) : div_rem_s;
               ALU_DIVU: fsm_result_s = div_quot_s;
               ALU_MODU: fsm_result_s = div_rem_s;
               default:  fsm_result_s = 32'd0;
            endcase
         end
         DONE:    fsm_next_s = IDLE;
         default: fsm_next_s = IDLE;
      endcase
   end

   // Flush forces IDLE and freezes the result.
   always_comb begin
      state_next_s  = flush ? IDLE : fsm_next_s;
      result_next_s = flush ? result_r : fsm_result_s;
   end

   // State, operand latch and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= 32'd0;
         op_r     <= ALU_ADD;
         src1_r   <= 32'd0;
         src2_r   <= 32'd0;
      end else begin
         state_r  <= state_next_s;
         busy_r   <= (state_next_s != IDLE);
         done_r   <= (state_next_s == DONE);
         result_r <= result_next_s;
         if (accept_s) begin
            op_r   <= aluctrl;
            src1_r <= aluSrc1;
            src2_r <= aluSrc2;
         end
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
   import cpuDefine::*;

   logic   clk = 1'b0;
   logic   rst, start, flush;
   AluCtrl aluctrl;
   DType   aluSrc1, aluSrc2;
   logic   busy, done;
   DType   result;

   mul_div_unit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .flush   (flush),
      .aluctrl (aluctrl),
      .aluSrc1 (aluSrc1),
      .aluSrc2 (aluSrc2),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      DType  res;
      int    lat;
      int    acc;
      string name;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   compared   = 0;
   int   mismatched = 0;
   DType last_res   = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic DType model(input AluCtrl op, input DType a, input DType b);
      longint      sa, sb, p;
      logic [63:0] pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
      pu = {32'd0, a} * {32'd0, b};
      case (op)
         ALU_MUL:   return p[31:0];
         ALU_MULH:  return p[63:32];
         ALU_MULHU: return pu[63:32];
         ALU_DIV:   return (b == 32'd0) ? 32'hFFFF_FFFF : DType'(sa / sb);
         ALU_MOD:   return (b == 32'd0) ? a : DType'(sa % sb);
         ALU_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
         ALU_MODU:  return (b == 32'd0) ? a : (a % b);
         default:   return 32'd0;
      endcase
   endfunction

   function automatic int latency(input AluCtrl op, input DType b);
      if (op == ALU_DIV || op == ALU_MOD || op == ALU_DIVU || op == ALU_MODU)
         return (b == 32'd0) ? 1 : 34;
      else
         return 2;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, required done=0", cyc);
         end else begin
            mon_e = sbq.pop_front();
            check({mon_e.name, "_result"}, result, mon_e.res);
            check({mon_e.name, "_latency"}, cyc - mon_e.acc, mon_e.lat);
            last_res = mon_e.res;
         end
      end
   end

   // Present a request once the unit is idle; optionally record the expectation.
   task automatic issue(input AluCtrl op, input DType a, input DType b, input bit push);
      int guard = 0;
      while (busy !== 1'b0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (busy !== 1'b0) begin
         compared++;
         mismatched++;
         $display("FAIL issue_timeout: got busy=%b, required 0", busy);
      end
      start = 1'b1; aluctrl = op; aluSrc1 = a; aluSrc2 = b;
      if (push) sbq.push_back('{model(op, a, b), latency(op, b), cyc, $sformatf("op%0d", op)});
      @(posedge clk); #1;
      start   = 1'b0;
      aluctrl = AluCtrl'(4'($urandom_range(0, 15)));
      aluSrc1 = $urandom;
      aluSrc2 = $urandom;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sbq.size() != 0 || busy !== 1'b0) && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (sbq.size() != 0 || busy !== 1'b0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic run(input AluCtrl op, input DType a, input DType b);
      issue(op, a, b, 1'b1);
      drain();
   endtask

   function automatic DType pick(input int mode);
      DType ext[4];
      ext[0] = 32'h8000_0000; ext[1] = 32'hFFFF_FFFF; ext[2] = 32'd1; ext[3] = 32'h7FFF_FFFF;
      case (mode)
         0:       return $urandom;
         1:       return DType'($urandom_range(0, 20));
         2:       return 32'd0;
         default: return ext[$urandom_range(0, 3)];
      endcase
   endfunction

   initial begin
      int c;
      AluCtrl op;
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      aluctrl = ALU_ADD; aluSrc1 = 32'd0; aluSrc2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      rst = 1'b0;

      run(ALU_MULH,  32'hFFFF_FFFE, 32'h0000_0003);
      run(ALU_MULHU, 32'hFFFF_FFFE, 32'h0000_0003);
      run(ALU_DIV,   32'hFFFF_FFF9, 32'd2);
      run(ALU_MOD,   32'hFFFF_FFF9, 32'd2);
      run(ALU_DIVU,  32'd100, 32'd0);
      run(ALU_MODU,  32'd100, 32'd0);
      run(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run(ALU_MOD,   32'h8000_0000, 32'hFFFF_FFFF);
      run(ALU_ADD,   32'd5, 32'd6);

      // Start held during a divide must be ignored.
      issue(ALU_DIV, 32'd1000, 32'd7, 1'b1);
      repeat (5) begin @(posedge clk); #1; end
      start = 1'b1; aluctrl = ALU_MUL; aluSrc1 = 32'd3; aluSrc2 = 32'd5;
      repeat (10) begin @(posedge clk); #1; end
      start = 1'b0;
      drain();

      // Flush in DONE: the pulse of that cycle still appears.
      issue(ALU_MUL, 32'd9, 32'd9, 1'b1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_in_done_busy", {31'd0, busy}, 32'd0);
      drain();

      // Flush together with start: nothing accepted.
      start = 1'b1; flush = 1'b1; aluctrl = ALU_MUL; aluSrc1 = 32'd2; aluSrc2 = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", {31'd0, busy}, 32'd0);
      repeat (3) begin @(posedge clk); #1; end

      // Flush mid-divide, then a multiply right after.
      c = cyc;
      issue(ALU_DIVU, 32'd1000, 32'd10, 1'b0);
      while (cyc < c + 10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_idle_busy", {31'd0, busy}, 32'd0);
      check("flush_result_kept", result, last_res);
      run(ALU_MUL, 32'd6, 32'd7);

      // Reset mid-divide.
      c = cyc;
      issue(ALU_DIV, 32'h1234_5678, 32'd3, 1'b0);
      while (cyc < c + 20) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_done", {31'd0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      rst = 1'b0;
      last_res = 32'd0;

      for (int i = 0; i < 60; i++) begin
         op = AluCtrl'(4'($urandom_range(0, 15)));
         if (i % 3 != 0) op = AluCtrl'(4'($urandom_range(6, 12)));
         run(op, pick($urandom_range(0, 3)), pick($urandom_range(0, 3)));
      end

      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
